serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 88 ++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b, LSB digit first, with registered result and flags.
// Optional SUB_ADD_MODE_EN adds an op port (0 = subtract, 1 = add).
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SUB_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             negative
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_n;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] sum;
  logic [DIGIT-1:0] b_d;
  logic cy, mode, op_in, accept, last;
`ifdef SUB_ADD_MODE_EN
  assign op_in = op;
`else
  assign op_in = 1'b0;
`endif
  assign accept = start && (state == IDLE || state == DONE);
  assign last = cnt == CW'(N - 1);
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_comb begin
    b_d = mode ? b_q[cnt*DIGIT +: DIGIT] : ~b_q[cnt*DIGIT +: DIGIT];
    sum = {1'b0, a_q[cnt*DIGIT +: DIGIT]} + {1'b0, b_d} + (DIGIT+1)'(cy);
    acc_n = acc;
    acc_n[cnt*DIGIT +: DIGIT] = sum[DIGIT-1:0];
  end
  always_comb begin
    state_n = IDLE;
    state_n = accept ? BUSY : (state == BUSY ? (last ? DONE : BUSY) : IDLE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // result/flags come from their own registers so they hold steady while acc fills
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cy <= 1'b0;
      mode <= 1'b0;
      cnt <= '0;
      result <= '0;
      overflow <= 1'b0;
      carry <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      cy <= ~op_in;
      mode <= op_in;
      cnt <= '0;
    end else if (busy) begin
      acc <= acc_n;
      cy <= sum[DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        result <= acc_n;
        carry <= sum[DIGIT];
        zero <= ~|acc_n;
        negative <= acc_n[M];
        overflow <= mode ? (~(a_q[M] ^ b_q[M]) & (a_q[M] ^ acc_n[M]))
                         : ((a_q[M] ^ b_q[M]) & ~(b_q[M] ^ acc_n[M]));
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=16, DIGIT=4) plus a DIGIT=WIDTH instance.
module tb_serial_subtractor;
  localparam int N = 4;
  typedef struct packed {
    logic [15:0] r;
    logic ov, cy, z, n;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
  logic [15:0] a = '0, b = '0, result, result1, held_r;
  logic busy, done, overflow, carry, zero, negative;
  logic busy1, done1, overflow1, carry1, zero1, negative1;
  exp_t sbq[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SUB_ADD_MODE_EN
    .op(op),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .overflow(overflow), .carry(carry), .zero(zero), .negative(negative));
  serial_subtractor #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef SUB_ADD_MODE_EN
    .op(op),
`endif
    .a(a), .b(b), .busy(busy1), .done(done1), .result(result1),
    .overflow(overflow1), .carry(carry1), .zero(zero1), .negative(negative1));
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic add);
    logic [16:0] s;
    exp_t e;
    s = add ? {1'b0, x} + {1'b0, y} : {1'b0, x} + {1'b0, ~y} + 17'd1;
    e.r = s[15:0];
    e.cy = s[16];
    e.z = s[15:0] == 16'h0;
    e.n = s[15];
    e.ov = add ? (x[15] == y[15] && s[15] != x[15]) : (x[15] != y[15] && s[15] != x[15]);
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic add);
    a = x;
    b = y;
    op = add;
    start = 1'b1;
    sbq.push_back(model(x, y, add));
  endtask
  task automatic wait_done(input int poke);
    exp_t e;
    for (int i = 1; i <= N + 1; i++) begin
      step();
      start = 1'b0;
      checks++;
      if (busy !== (i <= N) || done !== (i == N + 1)) begin
        errors++;
        $display("FAIL timing cycle %0d: busy=%b done=%b, want busy=%b done=%b", i, busy, done, i <= N, i == N + 1);
      end
      if (i <= N) begin
        checks++;
        if (result !== held_r) begin
          errors++;
          $display("FAIL result_hold cycle %0d: got %h want %h", i, result, held_r);
        end
      end else begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got done with no expectation, want one");
        end else begin
          e = sbq.pop_front();
          if ({result, overflow, carry, zero, negative} !== e) begin
            errors++;
            $display("FAIL result: got r=%h ov=%b c=%b z=%b n=%b want r=%h ov=%b c=%b z=%b n=%b",
                     result, overflow, carry, zero, negative, e.r, e.ov, e.cy, e.z, e.n);
          end
          held_r = e.r;
        end
      end
      if (i == poke) begin
        start = 1'b1;
        a = 16'h1111;
      end
    end
  endtask
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic add);
    issue(x, y, add);
    wait_done(0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, result, overflow, carry, zero, negative} !== 22'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b r=%h flags=%b%b%b%b want all 0",
               busy, done, result, overflow, carry, zero, negative);
    end
    rst = 1'b0;
    held_r = '0;
    step();
  endtask
  task automatic test_basic();
    run_op(16'h0005, 16'h0003, 1'b0);
    step();
    run_op(16'h8000, 16'h0001, 1'b0);
    step();
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'b0);
      step();
    end
  endtask
  task automatic test_back_to_back();
    run_op(16'h1234, 16'h1234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    step();
  endtask
  task automatic test_start_ignored();
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_done(2);
    step();
  endtask
  task automatic test_reset_mid();
    issue(16'h00FF, 16'h0001, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, result, overflow, carry, zero, negative} !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b r=%h flags=%b%b%b%b want all 0",
               busy, done, result, overflow, carry, zero, negative);
    end
    void'(sbq.pop_front());
    held_r = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet %0d: busy=%b done=%b want 0 0", i, busy, done);
      end
    end
    run_op(16'h00FF, 16'h0001, 1'b0);
    step();
  endtask
`ifdef SUB_ADD_MODE_EN
  task automatic test_add();
    run_op(16'h7FFF, 16'h0001, 1'b1);
    step();
    run_op(16'hFFFF, 16'h0001, 1'b1);
    step();
    op = 1'b0;
  endtask
`endif
  task automatic test_single_digit();
    exp_t e;
    e = model(16'h8000, 16'h0001, 1'b0);
    a = 16'h8000;
    b = 16'h0001;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL n1_busy: busy=%b done=%b want 1 0", busy1, done1);
    end
    step();
    checks++;
    if ({busy1, done1} !== 2'b01 || {result1, overflow1, carry1, zero1, negative1} !== e) begin
      errors++;
      $display("FAIL n1_done: busy=%b done=%b r=%h ov=%b c=%b want busy=0 done=1 r=%h ov=%b c=%b",
               busy1, done1, result1, overflow1, carry1, e.r, e.ov, e.cy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef SUB_ADD_MODE_EN
    test_add();
`endif
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
